// File: rtl/fm_arbiter_if.sv
// ---------------------------------------------------------------------------
// fm_arbiter_pkg / arbiter_if
//
// Purpose:
//   Shared default widths for the feature-map arbiter, and the requester
//   bundle that carries one read port and one write port into the arbiter.
//
// Coordinates are packed as {y, x}:
//   x = coord[COORD_BITS-1:0]
//   y = coord[2*COORD_BITS-1:COORD_BITS]
//
// Bundle signals (direction as seen by the arbiter modport):
//   coord_get   in   read coordinate {y, x}
//   read_req    in   read request, held until read_ready
//   coord_wtr   in   write coordinate {y, x}
//   data_in     in   packed write word, held until write_ready
//   write_req   in   write request, held until write_ready
//   data_out    out  last read word, stable between read responses
//   read_ready  out  one-cycle read completion pulse
//   write_ready out  one-cycle write completion pulse
// ---------------------------------------------------------------------------
package fm_arbiter_pkg;
  localparam int DEFAULT_COORD_BITS  = 6;
  localparam int DEFAULT_CHANNELS    = 4;
  localparam int DEFAULT_NEURON_BITS = 8;
endpackage

interface arbiter_if
  import fm_arbiter_pkg::*;
#(
  parameter int COORD_BITS       = DEFAULT_COORD_BITS,
  parameter int CHANNELS         = DEFAULT_CHANNELS,
  parameter int BITS_PER_CHANNEL = DEFAULT_NEURON_BITS
);
  localparam int WORD_BITS = CHANNELS * BITS_PER_CHANNEL;

  logic [2*COORD_BITS-1:0] coord_get;
  logic                    read_req;
  logic [2*COORD_BITS-1:0] coord_wtr;
  logic [WORD_BITS-1:0]    data_in;
  logic                    write_req;
  logic [WORD_BITS-1:0]    data_out;
  logic                    read_ready;
  logic                    write_ready;

  modport arbiter (
    input  coord_get, read_req, coord_wtr, data_in, write_req,
    output data_out, read_ready, write_ready
  );

  modport requester (
    output coord_get, read_req, coord_wtr, data_in, write_req,
    input  data_out, read_ready, write_ready
  );
endinterface

// File: rtl/fm_arbiter.sv
// ---------------------------------------------------------------------------
// fm_arbiter
//
// Purpose:
//   Serialises one read port and one write port onto a single-port
//   feature-map memory. Simultaneous requests are granted round-robin,
//   with the read port winning the first tie after reset. Coordinates
//   outside the map never reach the memory: writes are dropped, reads
//   return zero, and a sticky coord_err flag is raised.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   arb        --   arbiter_if.arbiter requester bundle
//   mem_en     out  memory access strobe
//   mem_we     out  memory write enable (only meaningful with mem_en)
//   mem_addr   out  linear address y*FM_WIDTH + x
//   mem_wdata  out  packed write word (channel c at [c*BPC +: BPC])
//   mem_rdata  in   read word, valid the cycle after a read strobe
//   coord_err  out  sticky out-of-range coordinate flag
//
// Optional feature (macro FM_ARBITER_STATS_EN):
//   rd_count, wr_count, conflict_count  16-bit saturating counters of read
//   ready pulses, write ready pulses, and IDLE cycles with both requests.
// ---------------------------------------------------------------------------
module fm_arbiter
  import fm_arbiter_pkg::*;
#(
  parameter int COORD_BITS       = DEFAULT_COORD_BITS,
  parameter int CHANNELS         = DEFAULT_CHANNELS,
  parameter int BITS_PER_CHANNEL = DEFAULT_NEURON_BITS,
  parameter int FM_WIDTH         = 32,
  parameter int FM_HEIGHT        = 32,
  parameter int ADDR_BITS        = $clog2(FM_WIDTH * FM_HEIGHT)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  arbiter_if.arbiter                           arb,
  output logic                                 mem_en,
  output logic                                 mem_we,
  output logic [ADDR_BITS-1:0]                 mem_addr,
  output logic [CHANNELS*BITS_PER_CHANNEL-1:0] mem_wdata,
  input  logic [CHANNELS*BITS_PER_CHANNEL-1:0] mem_rdata,
  output logic                                 coord_err
`ifdef FM_ARBITER_STATS_EN
  ,
  output logic [15:0]                          rd_count,
  output logic [15:0]                          wr_count,
  output logic [15:0]                          conflict_count
`else
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_WAIT,
    RD_RESP
  } state_t;

  state_t state;
  state_t next_state;

  // 1 when the most recent grant went to the write port. Resetting it to 1
  // makes the read port the winner of the first tie.
  logic last_was_wr;
  logic grant_wr;
  logic grant_rd;

  // Whether the access currently in flight targets a valid pixel.
  logic in_range_q;

  logic [COORD_BITS-1:0] wr_x;
  logic [COORD_BITS-1:0] wr_y;
  logic [COORD_BITS-1:0] rd_x;
  logic [COORD_BITS-1:0] rd_y;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic [ADDR_BITS-1:0]  wr_addr;
  logic [ADDR_BITS-1:0]  rd_addr;

  assign wr_x = arb.coord_wtr[COORD_BITS-1:0];
  assign wr_y = arb.coord_wtr[2*COORD_BITS-1:COORD_BITS];
  assign rd_x = arb.coord_get[COORD_BITS-1:0];
  assign rd_y = arb.coord_get[2*COORD_BITS-1:COORD_BITS];

  assign wr_in_range = (32'(wr_x) < FM_WIDTH) && (32'(wr_y) < FM_HEIGHT);
  assign rd_in_range = (32'(rd_x) < FM_WIDTH) && (32'(rd_y) < FM_HEIGHT);

  // Row-major linearisation; only used when the coordinate is in range, so
  // the truncation to ADDR_BITS never loses information that matters.
  assign wr_addr = ADDR_BITS'(wr_y) * ADDR_BITS'(FM_WIDTH) + ADDR_BITS'(wr_x);
  assign rd_addr = ADDR_BITS'(rd_y) * ADDR_BITS'(FM_WIDTH) + ADDR_BITS'(rd_x);

  // State register. Reset aborts whatever is in flight; because the strobes
  // are decoded from this register they fall as soon as rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, grant and strobe decode. Requests are only looked at in
  // IDLE; every other state lasts exactly one cycle.
  always_comb begin
    next_state      = state;
    grant_wr        = 1'b0;
    grant_rd        = 1'b0;
    mem_en          = 1'b0;
    mem_we          = 1'b0;
    arb.write_ready = 1'b0;
    arb.read_ready  = 1'b0;

    case (state)
      IDLE: begin
        if (arb.write_req && arb.read_req) begin
          grant_rd = last_was_wr;
          grant_wr = !last_was_wr;
        end else begin
          grant_wr = arb.write_req;
          grant_rd = arb.read_req;
        end
        if (grant_wr) begin
          next_state = WR;
        end else if (grant_rd) begin
          next_state = RD_ISSUE;
        end
      end
      WR: begin
        mem_en          = in_range_q;
        mem_we          = in_range_q;
        arb.write_ready = 1'b1;
        next_state      = IDLE;
      end
      RD_ISSUE: begin
        mem_en     = in_range_q;
        next_state = RD_WAIT;
      end
      RD_WAIT: begin
        next_state = RD_RESP;
      end
      RD_RESP: begin
        arb.read_ready = 1'b1;
        next_state     = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Grant-time capture of address, write data and range status, plus the
  // round-robin pointer and the sticky error flag. Out-of-range accesses
  // leave the memory-side registers untouched since no strobe will follow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_was_wr <= 1'b1;
      in_range_q  <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      coord_err   <= 1'b0;
    end else begin
      if (grant_wr) begin
        last_was_wr <= 1'b1;
        in_range_q  <= wr_in_range;
        if (wr_in_range) begin
          mem_addr  <= wr_addr;
          mem_wdata <= arb.data_in;
        end else begin
          coord_err <= 1'b1;
        end
      end else if (grant_rd) begin
        last_was_wr <= 1'b0;
        in_range_q  <= rd_in_range;
        if (rd_in_range) begin
          mem_addr <= rd_addr;
        end else begin
          coord_err <= 1'b1;
        end
      end
    end
  end

  // Read data capture. The memory word arrives during RD_WAIT and is held
  // in data_out until the next read response replaces it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arb.data_out <= '0;
    end else if (state == RD_WAIT) begin
      arb.data_out <= in_range_q ? mem_rdata : '0;
    end
  end

`ifdef FM_ARBITER_STATS_EN
  // Activity counters: ready pulses per port and IDLE cycles where both
  // ports were requesting. All saturate rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count       <= '0;
      wr_count       <= '0;
      conflict_count <= '0;
    end else begin
      if (arb.read_ready && (rd_count != 16'hFFFF)) begin
        rd_count <= rd_count + 16'd1;
      end
      if (arb.write_ready && (wr_count != 16'hFFFF)) begin
        wr_count <= wr_count + 16'd1;
      end
      if ((state == IDLE) && arb.read_req && arb.write_req &&
          (conflict_count != 16'hFFFF)) begin
        conflict_count <= conflict_count + 16'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/fm_arbiter.md
FM_ARBITER -- requirements
Module: fm_arbiter

Interface
REQ-001 SHALL have parameter COORD_BITS, default DEFAULT_COORD_BITS: width of each coordinate field.
REQ-002 SHALL have parameter CHANNELS, default DEFAULT_CHANNELS: channels per feature-map word.
REQ-003 SHALL have parameter BITS_PER_CHANNEL, default DEFAULT_NEURON_BITS: bits per channel.
REQ-004 SHALL have parameter FM_WIDTH, default 32: map width in pixels.
REQ-005 SHALL have parameter FM_HEIGHT, default 32: map height in pixels.
REQ-006 SHALL have parameter ADDR_BITS, default $clog2(FM_WIDTH*FM_HEIGHT): memory address width.
REQ-007 SHALL have one clock and an asynchronous, active-high reset.
REQ-008 SHALL have port clk, input, 1 bit: the single clock.
REQ-009 SHALL have port rst, input, 1 bit: the asynchronous, active-high reset.
REQ-010 SHALL have port arb, arbiter_if.arbiter modport, bundle: carries coord_get/read_req/coord_wtr/data_in/write_req (in) and data_out/read_ready/write_ready (out).
REQ-011 SHALL have port mem_en, output, 1 bit: memory access strobe.
REQ-012 SHALL have port mem_we, output, 1 bit: write enable, valid only with mem_en.
REQ-013 SHALL have port mem_addr, output, ADDR_BITS bits: linear address.
REQ-014 SHALL have port mem_wdata, output, CHANNELS*BITS_PER_CHANNEL bits: packed write word.
REQ-015 SHALL have port mem_rdata, input, CHANNELS*BITS_PER_CHANNEL bits: read word, valid one cycle after the mem_en read cycle.
REQ-016 SHALL have port coord_err, output, 1 bit: sticky out-of-range coordinate flag.

Function
REQ-017 SHALL implement FSM states IDLE, WR, RD_ISSUE, RD_WAIT, RD_RESP; all states other than IDLE are one cycle long.
REQ-018 Requester SHALL hold req and coordinate/data stable until its ready pulse; ready is a one-cycle completion pulse.
REQ-019 SHALL, in IDLE: write_req only -> WR; read_req only -> RD_ISSUE; both -> round-robin (grant the port not granted last); after reset the read port wins the first tie.
REQ-020 SHALL make transitions WR->IDLE, RD_ISSUE->RD_WAIT->RD_RESP->IDLE; requests are sampled only in IDLE.
REQ-021 SHALL compute address = y*FM_WIDTH + x; word packing places channel c at bits [c*BITS_PER_CHANNEL +: BITS_PER_CHANNEL].
REQ-022 SHALL, in WR: mem_en=1, mem_we=1, registered address/wdata, write_ready=1; write latency is 1 cycle after the grant cycle.
REQ-023 SHALL, in RD_ISSUE: mem_en=1, mem_we=0; SHALL register mem_rdata into data_out at the end of RD_WAIT; read_ready=1 in RD_RESP; read latency is 3 cycles after the grant cycle.
REQ-024 SHALL hold data_out stable from RD_RESP until the next RD_RESP.
REQ-025 SHALL treat an access with x>=FM_WIDTH or y>=FM_HEIGHT as out of range: no mem_en; writes are dropped; reads return all zeros; the ready pulse has normal timing; coord_err is set.
REQ-026 SHALL keep mem_en, mem_we, read_ready and write_ready at 0 in IDLE.
REQ-027 SHALL have no read-after-write forwarding, because the FSM serializes accesses.

Reset
REQ-028 SHALL, on rst: state=IDLE; mem_en, mem_we, read_ready, write_ready, coord_err=0; data_out all zeros; mem_addr/mem_wdata=0; round-robin pointer=read-first.
REQ-029 SHALL, on rst mid-transaction: abort immediately (mem_we drops asynchronously), issue no ready pulse for the aborted request, and require the requester to re-request.

Configuration
REQ-030 SHALL use macro FM_ARBITER_STATS_EN: when defined, adds outputs rd_count, wr_count and conflict_count (16 bits each, saturating at 0xFFFF, reset 0), counting ready pulses per port and IDLE cycles with both requests; when undefined, these ports and their logic are absent and behaviour is otherwise identical.

Verification
REQ-031 SHALL cover: write (3,2)=0xA5 per channel, FM_WIDTH=32 -> mem_addr=67, mem_we=1, write_ready one cycle after grant.
REQ-032 SHALL cover: read (3,2) with mem model returning the stored word -> data_out=0xA5 per channel, read_ready exactly 3 cycles after grant.
REQ-033 SHALL cover: read_req and write_req rising together from reset, both held -> read served first, then write, then read, alternating.
REQ-034 SHALL cover: write (40,0) then read (0,40) -> no mem_en, write_ready/read_ready at normal latency, data_out=0, coord_err=1 until rst.
REQ-035 SHALL cover: rst asserted during RD_WAIT -> no read_ready, all outputs at reset values, a new read afterwards completes normally.
REQ-036 SHALL cover, with FM_ARBITER_STATS_EN: 5 writes, 3 reads, 2 ties -> wr_count=5, rd_count=3, conflict_count=2.
